// File: rtl/mips_multicycle.sv
// Multicycle MIPS core: one shared ALU, one unified stallable memory port
// (req/ready), and a controller FSM that sequences both across cycles.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [5:0]  BLE_OPCODE = 6'b000110,
    parameter int          NREGS_LOG2 = 5
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_width,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        retire
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam int NREGS = 1 << NREGS_LOG2;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
    } state_t;

    state_t r_state, w_next;

    logic [31:0] r_pc, r_ir, r_a, r_b, r_aluout, r_mdr;
    logic [31:0] r_rf [0:NREGS-1];

    logic [5:0]            w_op, w_funct;
    logic [NREGS_LOG2-1:0] w_rs, w_rt, w_rd;
    logic [31:0]           w_simm, w_alu_y, w_addr;
    logic                  w_req, w_we, w_width, w_retire, w_taken;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_rs    = r_ir[21 +: NREGS_LOG2];
    assign w_rt    = r_ir[16 +: NREGS_LOG2];
    assign w_rd    = r_ir[11 +: NREGS_LOG2];
    assign w_simm  = {{16{r_ir[15]}}, r_ir[15:0]};

    // Shared ALU: operands and operation are selected by the current state.
    always_comb begin
        w_alu_y = 32'h0;
        case (r_state)
            S_FETCH:            w_alu_y = r_pc + 32'd4;
            S_DECODE:           w_alu_y = r_pc + (w_simm << 2);
            S_MEMADR, S_ADDIEX: w_alu_y = r_a + w_simm;
            S_BRANCH:           w_alu_y = r_a - r_b;
            S_EXEC: begin
                case (w_funct)
                    FN_ADD:  w_alu_y = r_a + r_b;
                    FN_SUB:  w_alu_y = r_a - r_b;
                    FN_AND:  w_alu_y = r_a & r_b;
                    FN_OR:   w_alu_y = r_a | r_b;
                    FN_SLT:  w_alu_y = ($signed(r_a) < $signed(r_b)) ? 32'd1 : 32'd0;
                    default: w_alu_y = 32'h0;
                endcase
            end
            default:            w_alu_y = 32'h0;
        endcase
    end

    // ble uses the raw sign of the wrapped difference; no overflow fix-up.
    assign w_taken = (w_op == OP_BEQ) ? (w_alu_y == 32'h0)
                                      : ((w_alu_y == 32'h0) || w_alu_y[31]);

    // Controller: next state plus memory-port and retire controls.
    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_width  = 1'b0;
        w_addr   = r_pc;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: begin
                if (w_op == OP_LW || w_op == OP_SW || w_op == OP_SB) w_next = S_MEMADR;
                else if (w_op == OP_RTYPE)                            w_next = S_EXEC;
                else if (w_op == OP_ADDI)                             w_next = S_ADDIEX;
                else if (w_op == OP_BEQ || w_op == BLE_OPCODE)        w_next = S_BRANCH;
                else if (w_op == OP_J)                                w_next = S_JUMP;
                else begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_MEMADR: w_next = (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                w_req  = 1'b1;
                w_addr = r_aluout;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_MEMWR: begin
                w_req   = 1'b1;
                w_we    = 1'b1;
                w_width = (w_op == OP_SB);
                w_addr  = r_aluout;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_EXEC:   w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            default:  w_next = S_FETCH;
        endcase
    end

    // Reset forces the port idle immediately so an abandoned access never completes.
    assign mem_req   = w_req & ~reset;
    assign mem_we    = w_we & ~reset;
    assign mem_width = w_width & ~reset;
    assign retire    = w_retire & ~reset;
    assign mem_addr  = w_addr;
    assign mem_wdata = r_b;
    assign pc        = r_pc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Datapath registers and register file, updated per controller state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= 32'h0;
            r_a      <= 32'h0;
            r_b      <= 32'h0;
            r_aluout <= 32'h0;
            r_mdr    <= 32'h0;
            for (int i = 0; i < NREGS; i++) r_rf[i] <= 32'h0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= w_alu_y;
                    end
                end
                S_DECODE: begin
                    r_a      <= r_rf[w_rs];
                    r_b      <= r_rf[w_rt];
                    r_aluout <= w_alu_y;
                end
                S_MEMADR, S_EXEC, S_ADDIEX: r_aluout <= w_alu_y;
                S_MEMRD:  if (mem_ready) r_mdr <= mem_rdata;
                S_MEMWB:  if (w_rt != '0) r_rf[w_rt] <= r_mdr;
                S_ALUWB:  if (w_rd != '0) r_rf[w_rd] <= r_aluout;
                S_ADDIWB: if (w_rt != '0) r_rf[w_rt] <= r_aluout;
                S_BRANCH: if (w_taken) r_pc <= r_aluout;
                S_JUMP:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                default:  ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle.sv
// Bench for mips_multicycle: unified memory model, directed scenarios and a
// randomized program checked against an instruction-level reference model.
module tb_mips_multicycle;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [5:0]  BLE = 6'b000110;
    localparam int          NR  = 47;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc, mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_we, mem_width, mem_ready, retire;

    always #5 clk = ~clk;

    mips_multicycle #(.RESET_PC(RPC), .BLE_OPCODE(BLE), .NREGS_LOG2(5)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .retire(retire)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; logic w; } wr_t;

    logic [31:0] mem [0:1023];
    logic [31:0] img [0:1023];
    logic [31:0] rm  [0:1023];
    logic [31:0] rregs [0:31];
    logic [31:0] rpc;
    wr_t         wlog[$];
    wr_t         wexp[$];
    logic        load_req = 1'b0;
    int          ready_mode = 0;
    logic        man_ready = 1'b1;
    int          tests = 0;
    int          fails = 0;

    assign mem_rdata = mem[mem_addr[11:2]];

    // Ready generator: always ready, random wait states, or bench-controlled.
    always @(negedge clk) begin
        if (ready_mode == 0)      mem_ready = 1'b1;
        else if (ready_mode == 1) mem_ready = ($urandom_range(0, 2) != 0);
        else                      mem_ready = man_ready;
    end

    // Memory: image load, or completes a transaction on a req&&ready edge.
    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 1024; i++) mem[i] = img[i];
        end else if (mem_req && mem_ready && mem_we) begin
            if (mem_width) mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] = mem_wdata[7:0];
            else           mem[mem_addr[11:2]] = mem_wdata;
            wlog.push_back('{mem_addr, mem_wdata, mem_width});
        end
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    task automatic clear_img();
        for (int i = 0; i < 1024; i++) img[i] = 32'h0;
    endtask

    task automatic start();
        reset = 1'b1;
        #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        #1;
    endtask

    task automatic tick(output bit r);
        @(negedge clk); #1 r = retire;
        @(posedge clk); #1;
    endtask

    task automatic ref_init();
        rpc = RPC;
        for (int i = 0; i < 32; i++) rregs[i] = 32'h0;
        for (int i = 0; i < 1024; i++) rm[i] = img[i];
        wexp.delete();
    endtask

    // Instruction-level model: executes one instruction, returns next pc and latency.
    task automatic ref_step(output logic [31:0] npc, output int lat);
        logic [31:0] ir, a, b, imm, res, ad, d;
        logic [5:0]  op;
        logic [4:0]  rs, rt, rd;
        ir  = rm[rpc[11:2]];
        op  = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
        imm = {{16{ir[15]}}, ir[15:0]};
        a   = rregs[rs]; b = rregs[rt];
        npc = rpc + 32'd4;
        lat = 2;
        if (op == 6'h00) begin
            lat = 4;
            case (ir[5:0])
                6'h20:   res = a + b;
                6'h22:   res = a - b;
                6'h24:   res = a & b;
                6'h25:   res = a | b;
                6'h2A:   res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default: res = 32'h0;
            endcase
            if (rd != 0) rregs[rd] = res;
        end else if (op == 6'h08) begin
            lat = 4;
            if (rt != 0) rregs[rt] = a + imm;
        end else if (op == 6'h23) begin
            lat = 5; ad = a + imm;
            if (rt != 0) rregs[rt] = rm[ad[11:2]];
        end else if (op == 6'h2B) begin
            lat = 4; ad = a + imm;
            rm[ad[11:2]] = b;
            wexp.push_back('{ad, b, 1'b0});
        end else if (op == 6'h28) begin
            lat = 4; ad = a + imm;
            d = rm[ad[11:2]];
            d[8*ad[1:0] +: 8] = b[7:0];
            rm[ad[11:2]] = d;
            wexp.push_back('{ad, b, 1'b1});
        end else if (op == 6'h04) begin
            lat = 3;
            if (a == b) npc = npc + (imm << 2);
        end else if (op == BLE) begin
            lat = 3; d = a - b;
            if (d == 0 || $signed(d) < 0) npc = npc + (imm << 2);
        end else if (op == 6'h02) begin
            lat = 3;
            npc = {npc[31:28], ir[25:0], 2'b00};
        end
        rpc = npc;
    endtask

    task automatic test_reset();
        bit r;
        clear_img();
        ready_mode = 0;
        reset = 1'b1;
        #1 load_req = 1'b1;
        @(posedge clk); #1 load_req = 1'b0;
        @(posedge clk); #1;
        tests++;
        if ({mem_req, mem_we, mem_width, retire} !== 4'b0000) begin
            fails++; $display("FAIL reset_ctrl got %b exp 0000", {mem_req, mem_we, mem_width, retire});
        end
        tests++;
        if (pc !== RPC) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, RPC); end
        reset = 1'b0; #1;
        tests++;
        if ({mem_req, mem_we} !== 2'b10) begin
            fails++; $display("FAIL first_fetch_req got %b exp 10", {mem_req, mem_we});
        end
        tests++;
        if (mem_addr !== RPC) begin fails++; $display("FAIL first_fetch_addr got %h exp %h", mem_addr, RPC); end
        tick(r);
        tests++;
        if (pc !== RPC + 32'd4) begin fails++; $display("FAIL pc_after_fetch got %h exp %h", pc, RPC + 32'd4); end
    endtask

    task automatic test_alu_store();
        int rc[5];
        int erc[5];
        int got, base;
        bit r;
        erc = '{4, 8, 12, 16, 20};
        rc  = '{0, 0, 0, 0, 0};
        clear_img();
        img[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
        img[65] = enc_i(6'h08, 5'd0, 5'd2, 16'd7);
        img[66] = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
        img[67] = enc_i(6'h2B, 5'd0, 5'd3, 16'd8);
        img[68] = enc_i(6'h28, 5'd0, 5'd1, 16'd12);
        ready_mode = 0;
        base = wlog.size();
        start();
        got = 0;
        for (int cyc = 1; cyc <= 60 && got < 5; cyc++) begin
            tick(r);
            if (r) begin rc[got] = cyc; got++; end
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (rc[i] !== erc[i]) begin fails++; $display("FAIL retire_cycle[%0d] got %0d exp %0d", i, rc[i], erc[i]); end
        end
        tests++;
        if (wlog.size() - base !== 2) begin
            fails++; $display("FAIL store_count got %0d exp 2", wlog.size() - base);
        end else begin
            tests++;
            if ({wlog[base].a, wlog[base].d, wlog[base].w} !== {32'd8, 32'd12, 1'b0}) begin
                fails++; $display("FAIL sw_write got a=%h d=%h w=%b exp a=8 d=c w=0", wlog[base].a, wlog[base].d, wlog[base].w);
            end
            tests++;
            if ({wlog[base+1].a, wlog[base+1].d[7:0], wlog[base+1].w} !== {32'd12, 8'd5, 1'b1}) begin
                fails++; $display("FAIL sb_write got a=%h d=%h w=%b exp a=c d=05 w=1", wlog[base+1].a, wlog[base+1].d[7:0], wlog[base+1].w);
            end
        end
    endtask

    task automatic test_lw_wait();
        int rc[2];
        int got, base;
        bit r;
        rc = '{0, 0};
        clear_img();
        img[512] = 32'hDEAD_BEEF;
        img[64]  = enc_i(6'h23, 5'd0, 5'd4, 16'h0800);
        img[65]  = enc_i(6'h2B, 5'd0, 5'd4, 16'h0804);
        ready_mode = 2; man_ready = 1'b1;
        base = wlog.size();
        start();
        got = 0;
        for (int cyc = 1; cyc <= 60 && got < 2; cyc++) begin
            man_ready = !(cyc >= 4 && cyc <= 6);
            if (cyc >= 4 && cyc <= 7) begin
                tests++;
                if ({mem_req, mem_we, mem_width, mem_addr} !== {3'b100, 32'h800}) begin
                    fails++; $display("FAIL lw_hold cyc %0d got req=%b we=%b w=%b a=%h exp 1 0 0 800",
                                      cyc, mem_req, mem_we, mem_width, mem_addr);
                end
            end
            tick(r);
            if (r) begin rc[got] = cyc; got++; end
        end
        tests++;
        if (rc[0] !== 8) begin fails++; $display("FAIL lw_latency got %0d exp 8", rc[0]); end
        tests++;
        if (rc[1] !== 12) begin fails++; $display("FAIL sw_after_lw_cycle got %0d exp 12", rc[1]); end
        tests++;
        if (wlog.size() - base !== 1) begin
            fails++; $display("FAIL lw_store_count got %0d exp 1", wlog.size() - base);
        end else begin
            tests++;
            if ({wlog[base].a, wlog[base].d} !== {32'h804, 32'hDEAD_BEEF}) begin
                fails++; $display("FAIL lw_value got a=%h d=%h exp a=804 d=deadbeef", wlog[base].a, wlog[base].d);
            end
        end
        ready_mode = 0;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic [15:0] av, input logic [15:0] bv, input string nm);
        int ia, ib, got, cyc3;
        bit r, taken;
        logic [31:0] pc3, epc;
        ia = $signed(av); ib = $signed(bv);
        taken = (op == BLE) ? (ia <= ib) : (ia == ib);
        epc = taken ? RPC + 32'd12 + 32'd20 : RPC + 32'd12;
        clear_img();
        img[64] = enc_i(6'h08, 5'd0, 5'd1, av);
        img[65] = enc_i(6'h08, 5'd0, 5'd2, bv);
        img[66] = enc_i(op, 5'd1, 5'd2, 16'd5);
        ready_mode = 0;
        start();
        got = 0; cyc3 = 0; pc3 = 32'hX;
        for (int cyc = 1; cyc <= 60 && got < 3; cyc++) begin
            tick(r);
            if (r) begin
                got++;
                if (got == 3) begin pc3 = pc; cyc3 = cyc; end
            end
        end
        tests++;
        if (pc3 !== epc) begin fails++; $display("FAIL %s pc got %h exp %h", nm, pc3, epc); end
        tests++;
        if (cyc3 !== 11) begin fails++; $display("FAIL %s retire_cycle got %0d exp 11", nm, cyc3); end
    endtask

    task automatic test_branch();
        run_branch(BLE,   16'hFFFD, 16'd2, "ble_neg");
        run_branch(BLE,   16'd2,    16'd2, "ble_eq");
        run_branch(BLE,   16'd3,    16'd2, "ble_gt");
        run_branch(6'h04, 16'd3,    16'd2, "beq_ne");
        run_branch(6'h04, 16'd7,    16'd7, "beq_eq");
    endtask

    task automatic test_reset_mid_write();
        int base, rcy;
        bit r, found;
        clear_img();
        img[64] = enc_i(6'h08, 5'd0, 5'd1, 16'd9);
        img[65] = enc_i(6'h2B, 5'd0, 5'd1, 16'h0840);
        ready_mode = 2; man_ready = 1'b1;
        base = wlog.size();
        start();
        found = 1'b0;
        for (int cyc = 1; cyc <= 40 && !found; cyc++) begin
            if (mem_req && mem_we) found = 1'b1;
            else tick(r);
        end
        tests++;
        if (found !== 1'b1) begin fails++; $display("FAIL memwr_reached got %b exp 1", found); end
        man_ready = 1'b0;
        tick(r); tick(r);
        reset = 1'b1;
        tick(r);
        man_ready = 1'b1;
        tests++;
        if ({mem_req, pc} !== {1'b0, RPC}) begin
            fails++; $display("FAIL midreset_state got req=%b pc=%h exp req=0 pc=%h", mem_req, pc, RPC);
        end
        tick(r);
        tests++;
        if (mem_req !== 1'b0) begin fails++; $display("FAIL midreset_req_hold got %b exp 0", mem_req); end
        reset = 1'b0; #1;
        tests++;
        if ({mem_req, mem_we, mem_addr} !== {2'b10, RPC}) begin
            fails++; $display("FAIL midreset_refetch got req=%b we=%b a=%h exp 1 0 %h", mem_req, mem_we, mem_addr, RPC);
        end
        tests++;
        if (wlog.size() - base !== 0 || mem[528] !== 32'h0) begin
            fails++; $display("FAIL midreset_no_write got n=%0d m=%h exp n=0 m=0", wlog.size() - base, mem[528]);
        end
        rcy = 0;
        for (int cyc = 1; cyc <= 20 && rcy == 0; cyc++) begin
            tick(r);
            if (r) rcy = cyc;
        end
        tests++;
        if (rcy !== 4) begin fails++; $display("FAIL midreset_restart_retire got %0d exp 4", rcy); end
        ready_mode = 0;
    endtask

    task automatic gen_prog();
        int p, sel;
        logic [4:0]  rs, rt, rd;
        logic [5:0]  fns [8];
        logic [31:0] w;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2A, 6'h00, 6'h26};
        clear_img();
        for (int k = 0; k < 16; k++) img[512+k] = $urandom;
        p = 64;
        for (int r = 1; r < 8; r++) begin
            img[p] = enc_i(6'h08, 5'd0, 5'(r), 16'($urandom));
            p++;
        end
        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 8);
            rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
            case (sel)
                0, 1:    w = enc_r(rs, rt, rd, fns[$urandom_range(0, 7)]);
                2:       w = enc_i(6'h08, rs, rt, 16'($urandom));
                3:       w = enc_i(6'h23, 5'd0, rt, 16'(32'h800 + 4*$urandom_range(0, 15)));
                4:       w = enc_i(6'h2B, 5'd0, rt, 16'(32'h800 + 4*$urandom_range(0, 15)));
                5:       w = enc_i(6'h28, 5'd0, rt, 16'(32'h800 + $urandom_range(0, 63)));
                6:       w = enc_i(6'h04, rs, rt, 16'($urandom_range(0, 3)));
                7:       w = enc_i(BLE, rs, rt, 16'($urandom_range(0, 3)));
                default: w = ($urandom_range(0, 1) != 0) ? {6'h02, 26'(p + 1 + $urandom_range(0, 3))}
                                                         : {6'h3F, 26'($urandom)};
            endcase
            img[p] = w;
            p++;
        end
    endtask

    task automatic run_random(input int mode, input bit chk_lat, input string tag);
        int base, got, last, elat;
        bit r;
        logic [31:0] epc;
        ready_mode = mode;
        ref_init();
        base = wlog.size();
        start();
        got = 0; last = 0;
        for (int cyc = 1; cyc <= 4000 && got < NR; cyc++) begin
            tick(r);
            if (r) begin
                got++;
                ref_step(epc, elat);
                tests++;
                if (pc !== epc) begin fails++; $display("FAIL %s pc[%0d] got %h exp %h", tag, got, pc, epc); end
                if (chk_lat) begin
                    tests++;
                    if (cyc - last !== elat) begin
                        fails++; $display("FAIL %s latency[%0d] got %0d exp %0d", tag, got, cyc - last, elat);
                    end
                end
                last = cyc;
            end
        end
        tests++;
        if (got !== NR) begin fails++; $display("FAIL %s retire_count got %0d exp %0d", tag, got, NR); end
        tests++;
        if (wlog.size() - base !== wexp.size()) begin
            fails++; $display("FAIL %s write_count got %0d exp %0d", tag, wlog.size() - base, wexp.size());
        end else begin
            for (int i = 0; i < wexp.size(); i++) begin
                tests++;
                if (wlog[base+i].a !== wexp[i].a || wlog[base+i].w !== wexp[i].w ||
                    (wexp[i].w ? (wlog[base+i].d[7:0] !== wexp[i].d[7:0]) : (wlog[base+i].d !== wexp[i].d))) begin
                    fails++; $display("FAIL %s write[%0d] got a=%h d=%h w=%b exp a=%h d=%h w=%b", tag, i,
                                      wlog[base+i].a, wlog[base+i].d, wlog[base+i].w, wexp[i].a, wexp[i].d, wexp[i].w);
                end
            end
        end
        for (int k = 0; k < 16; k++) begin
            tests++;
            if (mem[512+k] !== rm[512+k]) begin
                fails++; $display("FAIL %s data[%0d] got %h exp %h", tag, k, mem[512+k], rm[512+k]);
            end
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            gen_prog();
            run_random(0, 1'b1, "rand_nowait");
            run_random(1, 1'b0, "rand_wait");
        end
        ready_mode = 0;
    endtask

    initial begin
        test_reset();
        test_alu_store();
        test_lw_wait();
        test_branch();
        test_reset_mid_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
